// File: rtl/cla_seq_add_if.sv
// Handshake and result bundle for the sequential carry-lookahead adder.
interface cla_seq_add_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, sub,
    input  ready, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, sub,
    output ready, done, sum, c_out, ovf
  );
endinterface

// File: rtl/cla_seq_add.sv
// Multi-cycle WIDTH-bit adder that reuses one SLICE-bit carry-lookahead slice, LSB slice first.
// Optional feature macro: CLA_SEQ_ADD_SUB_EN enables subtraction via the sub input.
module cla_seq_add #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic          clk,
  input logic          rst,
  cla_seq_add_if.slave bus
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] sum_reg;
  logic             c_out_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] b_in;
  logic             c_in;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] s;
  logic [SLICE:0]   c;
  logic [WIDTH-1:0] sum_next;

`ifdef CLA_SEQ_ADD_SUB_EN
  // Subtraction as A + ~B + 1.
  assign b_in = bus.b ^ {WIDTH{bus.sub}};
  assign c_in = bus.sub;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_in       = bus.b;
  assign c_in       = 1'b0;
`endif

  assign last = (k == KW'(N - 1));

  // Slice select, per-bit generate/propagate, lookahead carries and sum.
  always_comb begin
    logic pp;
    logic cc;
    a_sl = SLICE'(a_reg >> (k * SLICE));
    b_sl = SLICE'(b_reg >> (k * SLICE));
    g    = a_sl & b_sl;
    p    = a_sl | b_sl;
    c    = '0;
    c[0] = carry_reg;
    for (int i = 0; i < int'(SLICE); i++) begin
      pp = p[i];
      cc = g[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cc | (pp & carry_reg);
    end
    s        = a_sl ^ b_sl ^ c[SLICE-1:0];
    sum_next = (sum_reg & ~(WIDTH'({SLICE{1'b1}}) << (k * SLICE)))
             | (WIDTH'(s) << (k * SLICE));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, slice write-back and carry chaining; sum is kept across starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      k         <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= b_in;
      carry_reg <= c_in;
      k         <= '0;
    end else if (step) begin
      sum_reg   <= sum_next;
      carry_reg <= c[SLICE];
      k         <= k + KW'(1);
      if (last) begin
        c_out_reg <= c[SLICE];
        ovf_reg   <= c[SLICE] ^ c[SLICE-1];
      end
    end
  end

  assign bus.ready = (state != RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_reg;
  assign bus.c_out = c_out_reg;
  assign bus.ovf   = ovf_reg;

endmodule
